// File: rtl/pattern_resp_compactor.sv
// pattern_resp_compactor
// Response compaction for the merged pattern netlists. The nine pattern
// outputs are folded into a 16-bit MISR over a programmable window, and the
// cycles in which the response changed are counted. Results are handed off
// through a start/done/ack handshake and remain readable until the next run.
//
// Optional build macro: PATTERN_COMPACTOR_PARITY_EN
//   When defined, adds output sig_par, a registered parity bit that always
//   equals the XOR-reduction of the signature output.
module pattern_resp_compactor #(
  parameter int SIG_W = 16,
  parameter int LEN_W = 8,
  parameter int EVT_W = 4
) (
  input  logic             blif_clk_net,
  input  logic             blif_reset_net,
  input  logic [8:0]       resp,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             ack,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic [EVT_W-1:0] event_cnt
`ifdef PATTERN_COMPACTOR_PARITY_EN
  ,
  output logic             sig_par
`endif
);

  // Feedback taps of x^16 + x^12 + x^5 + 1 (CCITT form).
  localparam logic [SIG_W-1:0] POLY     = SIG_W'(16'h1021);
  localparam logic [SIG_W-1:0] SIG_SEED = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CAPT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [SIG_W-1:0] sig_q, sig_nxt;
  logic [EVT_W-1:0] evt_q, evt_nxt;
  logic [8:0]       prev_q, prev_nxt;
  logic [LEN_W-1:0] rem_q, rem_nxt;

  // One MISR absorb: shift, conditional feedback, then inject the response.
  function automatic logic [SIG_W-1:0] misr_step(
    input logic [SIG_W-1:0] sig,
    input logic [8:0]       r
  );
    logic [SIG_W-1:0] shifted;
    shifted = {sig[SIG_W-2:0], 1'b0};
    if (sig[SIG_W-1]) begin
      shifted = shifted ^ POLY;
    end
    return shifted ^ SIG_W'(r);
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [EVT_W-1:0] sat_inc(input logic [EVT_W-1:0] cnt);
    if (cnt == '1) begin
      return cnt;
    end
    return cnt + EVT_W'(1);
  endfunction

  // Control state register.
  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and next-value logic for the whole capture datapath.
  always_comb begin
    state_nxt = state;
    sig_nxt   = sig_q;
    evt_nxt   = evt_q;
    prev_nxt  = prev_q;
    rem_nxt   = rem_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          sig_nxt  = SIG_SEED;
          evt_nxt  = '0;
          prev_nxt = '0;
          rem_nxt  = len;
          // An empty window skips capture and reports the bare seed.
          state_nxt = (len != '0) ? S_CAPT : S_DONE;
        end
      end
      S_CAPT: begin
        sig_nxt = misr_step(sig_q, resp);
        if (resp != prev_q) begin
          evt_nxt = sat_inc(evt_q);
        end
        prev_nxt = resp;
        rem_nxt  = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // start is deliberately not looked at here, even alongside ack.
        if (ack) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Signature, event counter and window bookkeeping; all cleared by reset so
  // an aborted window leaves nothing behind.
  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      sig_q  <= '0;
      evt_q  <= '0;
      prev_q <= '0;
      rem_q  <= '0;
    end else begin
      sig_q  <= sig_nxt;
      evt_q  <= evt_nxt;
      prev_q <= prev_nxt;
      rem_q  <= rem_nxt;
    end
  end

`ifdef PATTERN_COMPACTOR_PARITY_EN
  // Parity is taken from the next value so it lands in the same edge as the
  // signature it describes.
  always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
    if (!blif_reset_net) begin
      sig_par <= 1'b0;
    end else begin
      sig_par <= ^sig_nxt;
    end
  end
`endif

  assign busy      = (state == S_CAPT);
  assign done      = (state == S_DONE);
  assign signature = sig_q;
  assign event_cnt = evt_q;

endmodule
